vx_burst_arbiter: RTL and testbench

VX_BURST_ARBITER -- requirements
Module: VX_burst_arbiter

---
 rtl/vx_burst_arbiter.sv | 131 +++++++++++++
 tb/tb_vx_burst_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vx_burst_arbiter.sv
// Burst-aware round-robin arbiter: N streams into one registered output.
// A granted burst holds the output until its last beat is accepted.
module vx_burst_arbiter #(
   parameter  int NUM_REQS     = 4,
   parameter  int DATA_WIDTH   = 32,
   parameter  int MAX_BURST    = 16,
   localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   localparam int BCNT_W       = $clog2(MAX_BURST + 1)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQS-1:0]          valid_in,
   input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_REQS-1:0]          last_in,
   output logic [NUM_REQS-1:0]          ready_in,
   output logic                         valid_out,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         last_out,
   output logic [LOG_NUM_REQS-1:0]      sel_out,
   input  logic                         ready_out,
   output logic                         burst_err
);

   localparam int IW = LOG_NUM_REQS + 1;

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                  state_q, state_d;
   logic [LOG_NUM_REQS-1:0] ptr_q, owner_q;
   logic [LOG_NUM_REQS-1:0] rr_idx, gnt_idx, ptr_nxt;
   logic [IW-1:0]           rr_sum, nxt_sum;
   logic                    rr_vld, gnt_vld;
   logic                    load_en, xfer, xfer_last;
   logic [DATA_WIDTH-1:0]   gnt_data;
   logic [BCNT_W-1:0]       bcnt_q;

   // Scan downward so the closest requester at or after ptr wins.
   always_comb begin
      rr_idx = '0;
      rr_vld = 1'b0;
      rr_sum = '0;
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
         rr_sum = {1'b0, ptr_q} + IW'(k);
         if (rr_sum >= IW'(NUM_REQS))
            rr_sum = rr_sum - IW'(NUM_REQS);
         if (valid_in[rr_sum[LOG_NUM_REQS-1:0]]) begin
            rr_vld = 1'b1;
            rr_idx = rr_sum[LOG_NUM_REQS-1:0];
         end
      end
   end

   always_comb begin
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
      if (state_q == LOCKED) begin
         gnt_idx = owner_q;
         gnt_vld = valid_in[owner_q];
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NUM_REQS; i++)
         if (gnt_idx == LOG_NUM_REQS'(i))
            gnt_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign load_en   = !valid_out || ready_out;
   assign xfer      = gnt_vld && load_en && reset_n;
   assign xfer_last = xfer && last_in[gnt_idx];
   assign ready_in  = xfer ? (NUM_REQS'(1) << gnt_idx) : '0;

   always_comb begin
      nxt_sum = {1'b0, gnt_idx} + IW'(1);
      if (nxt_sum >= IW'(NUM_REQS))
         nxt_sum = '0;
      ptr_nxt = nxt_sum[LOG_NUM_REQS-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (xfer && !xfer_last) state_d = LOCKED;
         LOCKED:  if (xfer_last)          state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         last_out  <= 1'b0;
         sel_out   <= '0;
         burst_err <= 1'b0;
         ptr_q     <= '0;
         owner_q   <= '0;
         bcnt_q    <= '0;
      end else begin
         if (xfer) begin
            valid_out <= 1'b1;
            data_out  <= gnt_data;
            last_out  <= last_in[gnt_idx];
            sel_out   <= gnt_idx;
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
         if (xfer && state_q == IDLE && !xfer_last)
            owner_q <= gnt_idx;
         if (xfer_last) begin
            ptr_q  <= ptr_nxt;
            bcnt_q <= '0;
         end else if (xfer) begin
            // Saturate so an overlong burst cannot wrap back to a small count.
            if (bcnt_q != BCNT_W'(MAX_BURST))
               bcnt_q <= bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(MAX_BURST - 1))
               burst_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vx_burst_arbiter.sv
// Directed bench for vx_burst_arbiter: rotation, locking, back-pressure,
// burst overflow, owner stall and asynchronous reset.
module tb_vx_burst_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    valid_in, last_in, ready_in;
   logic [N*DW-1:0] data_in;
   logic            valid_out, last_out, ready_out, burst_err;
   logic [DW-1:0]   data_out;
   logic [1:0]      sel_out;

   int n_cmp = 0;
   int n_bad = 0;

   vx_burst_arbiter #(
      .NUM_REQS  (N),
      .DATA_WIDTH(DW),
      .MAX_BURST (MB)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .valid_in (valid_in),
      .data_in  (data_in),
      .last_in  (last_in),
      .ready_in (ready_in),
      .valid_out(valid_out),
      .data_out (data_out),
      .last_out (last_out),
      .sel_out  (sel_out),
      .ready_out(ready_out),
      .burst_err(burst_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dv(input int r, input int b);
      return 32'hD000_0000 | 32'(r << 8) | 32'(b);
   endfunction

   task automatic put(input int r, input int b);
      data_in[r*DW +: DW] = dv(r, b);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_valid"}, valid_out, 0);
      check({tag, "_last"},  last_out,  0);
      check({tag, "_data"},  data_out,  0);
      check({tag, "_sel"},   sel_out,   0);
      check({tag, "_err"},   burst_err, 0);
      check({tag, "_rdy"},   ready_in,  0);
   endtask

   initial begin
      reset_n   = 1'b0;
      valid_in  = 4'b1111;
      last_in   = 4'b1111;
      data_in   = '0;
      ready_out = 1'b1;
      for (int r = 0; r < N; r++) put(r, 0);
      #3;
      check_reset_outs("rst");
      tick;
      reset_n = 1'b1;
      #1;

      // Single-beat round robin
      check("rr_rdy0", ready_in, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         tick;
         check("rr_valid", valid_out, 1);
         check("rr_sel", sel_out, 32'(k % 4));
         check("rr_data", data_out, dv(k % 4, 0));
         check("rr_rdy", ready_in, 32'(4'b0001 << ((k + 1) % 4)));
      end
      valid_in = '0;
      tick;
      check("rr_drain", valid_out, 0);

      // Req 1 three-beat burst, req 0 waiting
      valid_in = 4'b0010; last_in = 4'b0000; put(1, 1);
      #1 check("lk_rdy1", ready_in, 4'b0010);
      tick;
      check("lk_sel1", sel_out, 1);
      check("lk_d1", data_out, dv(1, 1));
      valid_in = 4'b0011; last_in = 4'b0001; put(1, 2); put(0, 9);
      #1 check("lk_rdy2", ready_in, 4'b0010);
      tick;
      check("lk_d2", data_out, dv(1, 2));
      last_in = 4'b0011; put(1, 3);
      #1 check("lk_rdy3", ready_in, 4'b0010);
      tick;
      check("lk_d3", data_out, dv(1, 3));
      check("lk_sel3", sel_out, 1);
      check("lk_last3", last_out, 1);
      valid_in = 4'b0001;
      #1 check("lk_rdy0", ready_in, 4'b0001);
      tick;
      check("lk_sel0", sel_out, 0);
      check("lk_d0", data_out, dv(0, 9));
      valid_in = '0;
      tick;

      // Output back-pressure
      valid_in = 4'b0100; last_in = 4'b1111; put(2, 1);
      tick;
      check("bp_d1", data_out, dv(2, 1));
      ready_out = 1'b0; put(2, 2);
      #1 check("bp_rdy", ready_in, 0);
      repeat (3) begin
         tick;
         check("bp_hold", data_out, dv(2, 1));
         check("bp_valid", valid_out, 1);
         check("bp_rdy_h", ready_in, 0);
      end
      ready_out = 1'b1;
      #1 check("bp_rdy_go", ready_in, 4'b0100);
      tick;
      check("bp_d2", data_out, dv(2, 2));
      check("bp_valid2", valid_out, 1);
      valid_in = '0;
      tick;
      check("bp_drain", valid_out, 0);

      // Overlong burst from req 2
      valid_in = 4'b0100;
      #1 check("ob_rdy", ready_in, 4'b0100);
      for (int b = 1; b <= 5; b++) begin
         last_in = (b == 5) ? 4'b0100 : 4'b0000;
         put(2, b);
         tick;
         check("ob_data", data_out, dv(2, b));
         check("ob_err", burst_err, 32'(b >= 4));
         check("ob_last", last_out, 32'(b == 5));
      end
      valid_in = '0;
      tick;
      check("ob_sticky", burst_err, 1);

      // Owner stalls while req 0 waits
      valid_in = 4'b1000; last_in = 4'b0000; put(3, 1);
      #1 check("st_rdy3", ready_in, 4'b1000);
      tick;
      check("st_d1", data_out, dv(3, 1));
      valid_in = 4'b0001; last_in = 4'b0001; put(0, 7);
      #1 check("st_rdy_a", ready_in, 0);
      tick;
      check("st_vo_a", valid_out, 0);
      check("st_rdy_b", ready_in, 0);
      tick;
      check("st_vo_b", valid_out, 0);
      check("st_rdy_c", ready_in, 0);
      valid_in = 4'b1001; put(3, 2);
      #1 check("st_rdy_r", ready_in, 4'b1000);
      tick;
      check("st_d2", data_out, dv(3, 2));
      last_in = 4'b1001; put(3, 3);
      tick;
      check("st_d3", data_out, dv(3, 3));
      check("st_last", last_out, 1);
      check("st_rdy0", ready_in, 4'b0001);
      tick;
      check("st_sel0", sel_out, 0);
      check("st_d0", data_out, dv(0, 7));
      valid_in = '0;
      tick;

      // Asynchronous reset mid-burst
      valid_in = 4'b1000; last_in = 4'b0000; put(3, 1);
      tick;
      put(3, 2);
      tick;
      check("mr_d2", data_out, dv(3, 2));
      check("mr_err", burst_err, 1);
      reset_n = 1'b0;
      #1;
      check_reset_outs("mr");
      valid_in = 4'b1001; last_in = 4'b1111; put(0, 5);
      #1 reset_n = 1'b1;
      #1 check("mr_rdy0", ready_in, 4'b0001);
      tick;
      check("mr_sel0", sel_out, 0);
      check("mr_d0", data_out, dv(0, 5));
      valid_in = '0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
